// File: rtl/alu_muldiv_if.sv
// Operand, opcode, handshake and result bundle of the alu_muldiv execute unit.
// The datapath controller drives through master; the execute unit uses slave.
interface alu_muldiv_if #(
   parameter int WIDTH = 32
);
   logic [WIDTH-1:0] A;
   logic [WIDTH-1:0] B;
   logic [3:0]       fun;
   logic             start;
   logic [WIDTH-1:0] Y;
   logic             zero;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] hi;
   logic [WIDTH-1:0] lo;

   modport master (
      output A, B, fun, start,
      input  Y, zero, busy, done, hi, lo
   );

   modport slave (
      input  A, B, fun, start,
      output Y, zero, busy, done, hi, lo
   );
endinterface

// File: rtl/alu_muldiv.sv
// EX-stage execute unit: single-cycle logic/add/sub/slt plus an iterative
// shift-add multiplier and restoring divider that write the HI/LO registers.
module alu_muldiv #(
   parameter int WIDTH = 32
) (
   input  logic         clk,
   input  logic         rst_n,
   alu_muldiv_if.slave  bus
);

   localparam int CW = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

   state_t                 state, state_nxt;
   logic                   busy_q, done_q;
   logic [2*WIDTH-1:0]     acc;
   logic [WIDTH-1:0]       opnd, rem, hi_q, lo_q;
   logic [CW-1:0]          count;
   logic                   op_div, neg_lo, neg_hi;

   logic [WIDTH-1:0]       bb, sum, y_c;
   logic                   is_md;
   logic signed [WIDTH-1:0] a_s, b_s;
   logic                   sgn_a, sgn_b;
   logic [WIDTH-1:0]       mag_a, mag_b;
   logic [WIDTH:0]         mul_sum, div_sh, div_diff;
   logic [2*WIDTH-1:0]     prod;
   logic [WIDTH-1:0]       hi_fin, lo_fin;

   function automatic logic [WIDTH-1:0] cond_neg(input logic [WIDTH-1:0] v, input logic neg);
      return neg ? -v : v;
   endfunction

   function automatic logic [2*WIDTH-1:0] cond_neg2(input logic [2*WIDTH-1:0] v, input logic neg);
      return neg ? -v : v;
   endfunction

   // Single-cycle result, independent of the engine and of hi/lo
   always_comb begin
      bb  = bus.fun[3] ? ~bus.B : bus.B;
      sum = bus.A + bb + {{(WIDTH-1){1'b0}}, bus.fun[3]};
      y_c = '0;
      case (bus.fun[2:0])
         3'b000:  y_c = bus.A & bb;
         3'b001:  y_c = bus.A | bb;
         3'b010:  y_c = bus.A ^ bb;
         3'b011:  y_c = ~(bus.A | bb);
         3'b110:  y_c = sum;
         3'b111:  y_c = {{(WIDTH-1){1'b0}}, sum[WIDTH-1]};
         default: y_c = '0;
      endcase
   end

   assign bus.Y    = y_c;
   assign bus.zero = (y_c == '0);
   assign is_md    = (bus.fun[2:1] == 2'b10);

   // Launch operands: magnitudes for signed ops, signs kept separately
   always_comb begin
      a_s   = signed'(bus.A);
      b_s   = signed'(bus.B);
      sgn_a = bus.fun[3] && (a_s < 0);
      sgn_b = bus.fun[3] && (b_s < 0);
      mag_a = cond_neg(bus.A, sgn_a);
      mag_b = cond_neg(bus.B, sgn_b);
   end

   // One iteration of either engine; the divider's borrow picks the quotient bit
   always_comb begin
      mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : '0);
      div_sh   = {rem, acc[WIDTH-1]};
      div_diff = div_sh - {1'b0, opnd};
      prod     = cond_neg2(acc, neg_lo);
      hi_fin   = op_div ? cond_neg(rem, neg_hi) : prod[2*WIDTH-1:WIDTH];
      lo_fin   = op_div ? cond_neg(acc[WIDTH-1:0], neg_lo) : prod[WIDTH-1:0];
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (bus.start && is_md) state_nxt = RUN;
         RUN:     if (count == CW'(1)) state_nxt = FIN;
         FIN:     state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= IDLE;
         busy_q <= 1'b0;
         done_q <= 1'b0;
      end else begin
         state  <= state_nxt;
         busy_q <= (state_nxt != IDLE);
         done_q <= (state == FIN);
      end
   end

   // Engine datapath; reset clears everything so an aborted op leaves no trace
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc    <= '0;
         opnd   <= '0;
         rem    <= '0;
         count  <= '0;
         op_div <= 1'b0;
         neg_lo <= 1'b0;
         neg_hi <= 1'b0;
         hi_q   <= '0;
         lo_q   <= '0;
      end else begin
         case (state)
            IDLE: if (bus.start && is_md) begin
               // Dividend (div) or multiplier (mul) goes into the low half
               acc    <= {{WIDTH{1'b0}}, (bus.fun[0] ? mag_a : mag_b)};
               opnd   <= bus.fun[0] ? mag_b : mag_a;
               rem    <= '0;
               count  <= CW'(WIDTH);
               op_div <= bus.fun[0];
               neg_lo <= (sgn_a ^ sgn_b) && !(bus.fun[0] && (bus.B == '0));
               neg_hi <= bus.fun[0] && sgn_a;
            end
            RUN: begin
               count <= count - CW'(1);
               if (op_div) begin
                  if (!div_diff[WIDTH]) begin
                     rem              <= div_diff[WIDTH-1:0];
                     acc[WIDTH-1:0]   <= {acc[WIDTH-2:0], 1'b1};
                  end else begin
                     rem              <= div_sh[WIDTH-1:0];
                     acc[WIDTH-1:0]   <= {acc[WIDTH-2:0], 1'b0};
                  end
               end else begin
                  acc <= {mul_sum, acc[WIDTH-1:1]};
               end
            end
            FIN: begin
               hi_q <= hi_fin;
               lo_q <= lo_fin;
            end
            default: ;
         endcase
      end
   end

   assign bus.busy = busy_q;
   assign bus.done = done_q;
   assign bus.hi   = hi_q;
   assign bus.lo   = lo_q;

endmodule

// File: tb/tb_alu_muldiv.sv
// Directed bench for alu_muldiv at WIDTH=32 (hand-computed vectors) and
// WIDTH=8 (vectors checked against an integer reference model).
module tb_alu_muldiv;

   logic clk;
   logic rst_n;
   int   checks;
   int   failures;

   alu_muldiv_if #(.WIDTH(32)) b32 ();
   alu_muldiv_if #(.WIDTH(8))  b8 ();

   alu_muldiv #(.WIDTH(32)) dut32 (.clk(clk), .rst_n(rst_n), .bus(b32));
   alu_muldiv #(.WIDTH(8))  dut8  (.clk(clk), .rst_n(rst_n), .bus(b8));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   localparam logic [7:0] VA [0:8] = '{8'hFF, 8'hFD, 8'hF9, 8'h64, 8'h80, 8'h09, 8'h80, 8'h7F, 8'h00};
   localparam logic [7:0] VB [0:8] = '{8'hFF, 8'h07, 8'h02, 8'h07, 8'hFF, 8'h00, 8'h00, 8'h80, 8'h05};
   localparam logic [3:0] FUNS [0:3] = '{4'h4, 4'h5, 4'hC, 4'hD};

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
      end
   endtask

   function automatic logic get_busy(input bit s);
      return s ? b8.busy : b32.busy;
   endfunction

   function automatic logic get_done(input bit s);
      return s ? b8.done : b32.done;
   endfunction

   function automatic logic [31:0] get_hi(input bit s);
      return s ? {24'h0, b8.hi} : b32.hi;
   endfunction

   function automatic logic [31:0] get_lo(input bit s);
      return s ? {24'h0, b8.lo} : b32.lo;
   endfunction

   task automatic set_in(input bit s, input logic [31:0] a, input logic [31:0] b,
                         input logic [3:0] f, input logic st);
      if (s) begin
         b8.A = a[7:0]; b8.B = b[7:0]; b8.fun = f; b8.start = st;
      end else begin
         b32.A = a; b32.B = b; b32.fun = f; b32.start = st;
      end
   endtask

   // Reference: plain integer arithmetic, truncating division
   function automatic logic [15:0] model8(input logic [7:0] a, input logic [7:0] b, input logic [3:0] f);
      int sa, sb, ua, ub, p, q, r;
      ua = int'(a);
      ub = int'(b);
      sa = a[7] ? ua - 256 : ua;
      sb = b[7] ? ub - 256 : ub;
      if (!f[0]) begin
         p = f[3] ? sa * sb : ua * ub;
         return p[15:0];
      end
      if (b == 8'h00) return {a, 8'hFF};
      if (f[3]) begin
         q = sa / sb;
         r = sa % sb;
      end else begin
         q = ua / ub;
         r = ua % ub;
      end
      return {r[7:0], q[7:0]};
   endfunction

   // Launch at the next edge, scramble operands, optionally poke a stray start, time done
   task automatic run_op(input bit s, input logic [31:0] a, input logic [31:0] b,
                         input logic [3:0] f, input logic [31:0] eh, input logic [31:0] el,
                         input int inject, input string tag);
      int n;
      int lat;
      lat = s ? 9 : 33;
      set_in(s, a, b, f, 1'b1);
      @(posedge clk); #1;
      set_in(s, ~a, ~b, 4'b0110, 1'b0);
      check({tag, "/busy"}, 64'(get_busy(s)), 64'd1);
      check({tag, "/done_lo"}, 64'(get_done(s)), 64'd0);
      n = 0;
      do begin
         set_in(s, 32'h3, 32'h3, (n == inject) ? 4'b0101 : 4'b0110, (n == inject));
         @(posedge clk); #1;
         n++;
      end while (!get_done(s) && n < 200);
      set_in(s, 32'h0, 32'h0, 4'b0110, 1'b0);
      check({tag, "/lat"}, 64'(n), 64'(lat));
      check({tag, "/hi"}, 64'(get_hi(s)), 64'(eh));
      check({tag, "/lo"}, 64'(get_lo(s)), 64'(el));
   endtask

   task automatic comb_chk(input logic [31:0] a, input logic [31:0] b, input logic [3:0] f,
                           input logic [31:0] ey, input logic ez, input string tag);
      b32.A = a; b32.B = b; b32.fun = f; b32.start = 1'b0;
      #1;
      check({tag, "/Y"}, 64'(b32.Y), 64'(ey));
      check({tag, "/zero"}, 64'(b32.zero), 64'(ez));
   endtask

   initial begin
      int dn;
      logic [15:0] m;
      checks   = 0;
      failures = 0;
      rst_n    = 1'b0;
      set_in(1'b0, 32'h0, 32'h0, 4'h0, 1'b0);
      set_in(1'b1, 32'h0, 32'h0, 4'h0, 1'b0);
      repeat (2) @(posedge clk);
      #1;
      check("rst/busy", 64'(b32.busy), 64'd0);
      check("rst/done", 64'(b32.done), 64'd0);
      check("rst/hi", 64'(b32.hi), 64'd0);
      check("rst/lo", 64'(b32.lo), 64'd0);
      rst_n = 1'b1;
      @(posedge clk); #1;

      comb_chk(32'd5, 32'd7, 4'b1110, 32'hFFFF_FFFE, 1'b0, "sub");
      comb_chk(32'd5, 32'd7, 4'b1111, 32'h1, 1'b0, "slt");
      comb_chk(32'h0F0F_0F0F, 32'h0F0F_0F0F, 4'b1110, 32'h0, 1'b1, "sub_eq");
      comb_chk(32'd5, 32'd7, 4'b0000, 32'd5, 1'b0, "and");
      comb_chk(32'd5, 32'd7, 4'b0001, 32'd7, 1'b0, "or");
      comb_chk(32'd5, 32'd7, 4'b0010, 32'd2, 1'b0, "xor");
      comb_chk(32'd5, 32'd7, 4'b0011, 32'hFFFF_FFF8, 1'b0, "nor");
      comb_chk(32'd5, 32'd7, 4'b0110, 32'd12, 1'b0, "add");
      comb_chk(32'd7, 32'd5, 4'b1111, 32'h0, 1'b1, "slt_ge");
      comb_chk(32'd5, 32'd7, 4'b1101, 32'h0, 1'b1, "md_code");
      b8.A = 8'd5; b8.B = 8'd7; b8.fun = 4'b1111;
      #1;
      check("slt8/Y", 64'(b8.Y), 64'd1);
      b8.fun = 4'b0110;
      @(posedge clk); #1;

      run_op(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'b0100, 32'hFFFF_FFFE, 32'h0000_0001, -1, "multu");
      run_op(1'b0, 32'hFFFF_FFFD, 32'd7, 4'b1100, 32'hFFFF_FFFF, 32'hFFFF_FFEB, -1, "mult");
      run_op(1'b0, 32'hFFFF_FFF9, 32'd2, 4'b1101, 32'hFFFF_FFFF, 32'hFFFF_FFFD, -1, "div");
      run_op(1'b0, 32'd100, 32'd7, 4'b0101, 32'd2, 32'd14, 4, "divu_stray");
      run_op(1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 4'b1101, 32'h0, 32'h8000_0000, -1, "div_ovf_b2b");
      run_op(1'b0, 32'd9, 32'd0, 4'b0101, 32'd9, 32'hFFFF_FFFF, -1, "divu0");

      set_in(1'b0, 32'd1, 32'd2, 4'b0110, 1'b1);
      #1;
      check("add_start/Y", 64'(b32.Y), 64'd3);
      @(posedge clk); #1;
      set_in(1'b0, 32'd0, 32'd0, 4'b0110, 1'b0);
      check("add_start/busy", 64'(b32.busy), 64'd0);
      @(posedge clk); #1;
      check("add_start/done", 64'(b32.done), 64'd0);
      check("hold/hi", 64'(b32.hi), 64'd9);
      check("hold/lo", 64'(b32.lo), 64'hFFFF_FFFF);

      for (int fi = 0; fi < 4; fi++) begin
         for (int vi = 0; vi < 9; vi++) begin
            m = model8(VA[vi], VB[vi], FUNS[fi]);
            run_op(1'b1, {24'h0, VA[vi]}, {24'h0, VB[vi]}, FUNS[fi],
                   {24'h0, m[15:8]}, {24'h0, m[7:0]}, -1, $sformatf("w8_f%0h_%0d", FUNS[fi], vi));
         end
      end

      // Asynchronous reset in the middle of a multiply
      set_in(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'b0100, 1'b1);
      @(posedge clk); #1;
      set_in(1'b0, 32'h0, 32'h0, 4'b0110, 1'b0);
      repeat (5) @(posedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      check("arst/busy", 64'(b32.busy), 64'd0);
      check("arst/done", 64'(b32.done), 64'd0);
      check("arst/hi", 64'(b32.hi), 64'd0);
      check("arst/lo", 64'(b32.lo), 64'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      dn = 0;
      repeat (40) begin
         @(posedge clk); #1;
         if (b32.done) dn++;
      end
      check("arst/no_done", 64'(dn), 64'd0);
      check("arst/hi_after", 64'(b32.hi), 64'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
